// File: rtl/mc_control_unit_if.sv
// Control bundle between the instruction register / datapath and the multicycle control unit.
// The master side is the control unit: it reads IR fields and ALU overflow, and drives every strobe.
interface mc_control_unit_if #(
    parameter int ADDR_W = 32
);
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic              overflow;
    logic              pc_write;
    logic              pc_write_cond;
    logic              branch_ne;
    logic [1:0]        pc_src;
    logic [1:0]        iord;
    logic              mem_write;
    logic              ir_write;
    logic              mdr_load;
    logic              reg_a_load;
    logic              reg_b_load;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [2:0]        alu_op;
    logic              alu_out_write;
    logic              reg_write;
    logic [1:0]        reg_dst;
    logic [1:0]        mem_to_reg;
    logic              epc_write;
    logic [1:0]        exc_cause;
    logic [ADDR_W-1:0] exc_vec_addr;
    logic              instr_done;

    modport master (
        input  opcode, funct, overflow,
        output pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_write, ir_write,
               mdr_load, reg_a_load, reg_b_load, alu_src_a, alu_src_b, alu_op,
               alu_out_write, reg_write, reg_dst, mem_to_reg, epc_write, exc_cause,
               exc_vec_addr, instr_done
    );

    modport slave (
        output opcode, funct, overflow,
        input  pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_write, ir_write,
               mdr_load, reg_a_load, reg_b_load, alu_src_a, alu_src_b, alu_op,
               alu_out_write, reg_write, reg_dst, mem_to_reg, epc_write, exc_cause,
               exc_vec_addr, instr_done
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control unit: Moore FSM with memory wait-state counting and
// vectored exceptions (invalid opcode, arithmetic overflow).
module mc_control_unit #(
    parameter int MEM_WAIT = 1,
    parameter int ADDR_W   = 32,
    parameter int VEC_BASE = 253
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_control_unit_if.master    bus,
    output logic [4:0]           state_dbg
);
    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_EXC, S_EXC_RD, S_EXC_PC
    } state_t;

    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(MEM_WAIT);

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_JR  = 6'h08;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       cause, cause_next;
    logic             cnt_zero;

    assign cnt_zero  = (cnt == '0);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RST;
            cnt   <= '0;
            cause <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cause <= cause_next;
        end
    end

    assign bus.exc_cause    = cause;
    assign bus.exc_vec_addr = ADDR_W'(VEC_BASE) + ADDR_W'(cause);

    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        cause_next        = cause;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_src        = 2'd0;
        bus.iord          = 2'd0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mdr_load      = 1'b0;
        bus.reg_a_load    = 1'b0;
        bus.reg_b_load    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = ALU_PASS;
        bus.alu_out_write = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 2'd0;
        bus.mem_to_reg    = 2'd0;
        bus.epc_write     = 1'b0;
        bus.instr_done    = 1'b0;

        case (state)
            S_RST: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'd3;
                bus.mem_to_reg = 2'd3;
                state_next     = S_FETCH;
            end
            S_FETCH: begin
                bus.alu_src_b = 2'd1;
                bus.alu_op    = ALU_ADD;
                if (!cnt_zero) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alu_src_b     = 2'd3;
                bus.alu_op        = ALU_ADD;
                bus.alu_out_write = 1'b1;
                bus.reg_a_load    = 1'b1;
                bus.reg_b_load    = 1'b1;
                case (bus.opcode)
                    6'h00: begin
                        if (bus.funct == F_ADD || bus.funct == F_SUB || bus.funct == F_AND)
                            state_next = S_EXEC_R;
                        else if (bus.funct == F_JR)
                            state_next = S_JR;
                        else begin
                            state_next = S_EXC;
                            cause_next = 2'd0;
                        end
                    end
                    6'h08, 6'h09: state_next = S_EXEC_I;
                    6'h23, 6'h2B: state_next = S_MEM_ADDR;
                    6'h04, 6'h05: state_next = S_BRANCH;
                    6'h02:        state_next = S_JUMP;
                    default: begin
                        state_next = S_EXC;
                        cause_next = 2'd0;
                    end
                endcase
            end
            S_EXEC_R: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_out_write = 1'b1;
                case (bus.funct)
                    F_SUB:   bus.alu_op = ALU_SUB;
                    F_AND:   bus.alu_op = ALU_AND;
                    default: bus.alu_op = ALU_ADD;
                endcase
                if (bus.overflow && bus.funct != F_AND) begin
                    state_next = S_EXC;
                    cause_next = 2'd1;
                end else begin
                    state_next = S_WB_R;
                end
            end
            S_WB_R: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'd1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_src_b     = 2'd2;
                bus.alu_op        = ALU_ADD;
                bus.alu_out_write = 1'b1;
                if (state == S_MEM_ADDR)
                    state_next = (bus.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
                else if (bus.overflow && bus.opcode == 6'h08) begin
                    state_next = S_EXC;
                    cause_next = 2'd1;
                end else
                    state_next = S_WB_I;
            end
            S_WB_I: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEM_RD, S_EXC_RD: begin
                bus.iord = (state == S_MEM_RD) ? 2'd1 : 2'd2;
                if (!cnt_zero) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    bus.mdr_load = 1'b1;
                    state_next   = (state == S_MEM_RD) ? S_WB_LW : S_EXC_PC;
                end
            end
            S_WB_LW: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'd1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEM_WR: begin
                bus.iord       = 2'd1;
                bus.mem_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'd1;
                bus.branch_ne     = (bus.opcode == 6'h05);
                bus.instr_done    = 1'b1;
                state_next        = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = 2'd2;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_JR: begin
                bus.alu_src_a  = 1'b1;
                bus.pc_write   = 1'b1;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            S_EXC: begin
                bus.alu_src_b = 2'd1;
                bus.alu_op    = ALU_SUB;
                bus.epc_write = 1'b1;
                state_next    = S_EXC_RD;
            end
            S_EXC_PC: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = 2'd3;
                bus.instr_done = 1'b1;
                state_next     = S_FETCH;
            end
            default: state_next = S_RST;
        endcase

        // Every entry into a memory-reading state restarts the wait count.
        if (state_next != state &&
            (state_next == S_FETCH || state_next == S_MEM_RD || state_next == S_EXC_RD))
            cnt_next = WAIT_LD;
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: two instances (MEM_WAIT=1 and 3) share inputs; each cycle the
// full control word of the selected instance is compared against the hand-written state table.
module tb_mc_control_unit;
    typedef struct packed {
        logic       pc_write, pc_write_cond, branch_ne;
        logic [1:0] pc_src, iord;
        logic       mem_write, ir_write, mdr_load, reg_a_load, reg_b_load, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       epc_write, instr_done;
    } ctl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_control_unit_if #(.ADDR_W(32)) bus1 ();
    mc_control_unit_if #(.ADDR_W(32)) bus3 ();
    logic [4:0] dbg1, dbg3;

    mc_control_unit #(.MEM_WAIT(1), .ADDR_W(32), .VEC_BASE(253)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .state_dbg(dbg1));
    mc_control_unit #(.MEM_WAIT(3), .ADDR_W(32), .VEC_BASE(253)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .state_dbg(dbg3));

    ctl_t        got1, got3, got;
    logic        sel = 1'b0;
    logic [1:0]  got_cause;
    logic [31:0] got_vec;
    int          w = 1;
    int          total = 0;
    int          bad = 0;

    assign got1 = {bus1.pc_write, bus1.pc_write_cond, bus1.branch_ne, bus1.pc_src, bus1.iord,
                   bus1.mem_write, bus1.ir_write, bus1.mdr_load, bus1.reg_a_load, bus1.reg_b_load,
                   bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op, bus1.alu_out_write, bus1.reg_write,
                   bus1.reg_dst, bus1.mem_to_reg, bus1.epc_write, bus1.instr_done};
    assign got3 = {bus3.pc_write, bus3.pc_write_cond, bus3.branch_ne, bus3.pc_src, bus3.iord,
                   bus3.mem_write, bus3.ir_write, bus3.mdr_load, bus3.reg_a_load, bus3.reg_b_load,
                   bus3.alu_src_a, bus3.alu_src_b, bus3.alu_op, bus3.alu_out_write, bus3.reg_write,
                   bus3.reg_dst, bus3.mem_to_reg, bus3.epc_write, bus3.instr_done};
    assign got       = sel ? got3 : got1;
    assign got_cause = sel ? bus3.exc_cause : bus1.exc_cause;
    assign got_vec   = sel ? bus3.exc_vec_addr : bus1.exc_vec_addr;

    function automatic ctl_t model(input string s);
        ctl_t c;
        c = '0;
        case (s)
            "RST":      begin c.reg_write = 1; c.reg_dst = 3; c.mem_to_reg = 3; end
            "FETCH_W":  begin c.alu_src_b = 1; c.alu_op = 3'b001; end
            "FETCH":    begin c.alu_src_b = 1; c.alu_op = 3'b001; c.ir_write = 1; c.pc_write = 1; end
            "DECODE":   begin c.alu_src_b = 3; c.alu_op = 3'b001; c.alu_out_write = 1;
                              c.reg_a_load = 1; c.reg_b_load = 1; end
            "EXEC_ADD": begin c.alu_src_a = 1; c.alu_op = 3'b001; c.alu_out_write = 1; end
            "EXEC_SUB": begin c.alu_src_a = 1; c.alu_op = 3'b010; c.alu_out_write = 1; end
            "EXEC_AND": begin c.alu_src_a = 1; c.alu_op = 3'b011; c.alu_out_write = 1; end
            "WB_R":     begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
            "EXEC_I", "MEM_ADDR":
                        begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_op = 3'b001; c.alu_out_write = 1; end
            "WB_I":     begin c.reg_write = 1; c.instr_done = 1; end
            "MEM_RD_W": begin c.iord = 1; end
            "MEM_RD":   begin c.iord = 1; c.mdr_load = 1; end
            "WB_LW":    begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
            "MEM_WR":   begin c.iord = 1; c.mem_write = 1; c.instr_done = 1; end
            "BEQ":      begin c.alu_src_a = 1; c.alu_op = 3'b010; c.pc_write_cond = 1; c.pc_src = 1;
                              c.instr_done = 1; end
            "BNE":      begin c.alu_src_a = 1; c.alu_op = 3'b010; c.pc_write_cond = 1; c.pc_src = 1;
                              c.branch_ne = 1; c.instr_done = 1; end
            "JUMP":     begin c.pc_write = 1; c.pc_src = 2; c.instr_done = 1; end
            "JR":       begin c.alu_src_a = 1; c.alu_op = 3'b000; c.pc_write = 1; c.instr_done = 1; end
            "EXC":      begin c.alu_src_b = 1; c.alu_op = 3'b010; c.epc_write = 1; end
            "EXC_RD_W": begin c.iord = 2; end
            "EXC_RD":   begin c.iord = 2; c.mdr_load = 1; end
            "EXC_PC":   begin c.pc_write = 1; c.pc_src = 3; c.instr_done = 1; end
            default:    c = '1;
        endcase
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input string s);
        @(negedge clk);
        check(s, 32'(got), 32'(model(s)));
    endtask

    task automatic fetch();
        repeat (w) cyc("FETCH_W");
        cyc("FETCH");
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
        bus1.opcode = op; bus1.funct = fn; bus1.overflow = ovf;
        bus3.opcode = op; bus3.funct = fn; bus3.overflow = ovf;
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        @(posedge clk);
        #1 check("rst_hold", 32'(got), 32'(model("RST")));
        check("rst_cause", 32'(got_cause), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc("RST");
    endtask

    task automatic exc_tail(input logic [1:0] cause);
        check("exc_cause", 32'(got_cause), 32'(cause));
        check("exc_vec", got_vec, 32'd253 + 32'(cause));
        repeat (w) cyc("EXC_RD_W");
        cyc("EXC_RD");
        cyc("EXC_PC");
    endtask

    initial begin
        set_instr(6'h00, 6'h20, 1'b0);
        sel = 1'b0; w = 1;
        rst_pulse();

        set_instr(6'h00, 6'h20, 1'b0);          // add
        fetch(); cyc("DECODE"); cyc("EXEC_ADD"); cyc("WB_R");

        set_instr(6'h08, 6'h00, 1'b1);          // addi, overflow
        fetch(); cyc("DECODE"); cyc("EXEC_I"); cyc("EXC"); exc_tail(2'd1);

        set_instr(6'h09, 6'h00, 1'b1);          // addiu, overflow ignored
        fetch(); cyc("DECODE"); cyc("EXEC_I"); cyc("WB_I");
        check("cause_hold", 32'(got_cause), 32'd1);

        set_instr(6'h3F, 6'h00, 1'b0);          // invalid opcode
        fetch(); cyc("DECODE"); cyc("EXC"); exc_tail(2'd0);

        set_instr(6'h00, 6'h24, 1'b1);          // and never traps
        fetch(); cyc("DECODE"); cyc("EXEC_AND"); cyc("WB_R");

        set_instr(6'h05, 6'h00, 1'b0);          // bne
        fetch(); cyc("DECODE"); cyc("BNE");
        set_instr(6'h04, 6'h00, 1'b1);          // beq, overflow outside EXEC ignored
        fetch(); cyc("DECODE"); cyc("BEQ");

        set_instr(6'h2B, 6'h00, 1'b0);          // sw
        fetch(); cyc("DECODE"); cyc("MEM_ADDR"); cyc("MEM_WR");
        set_instr(6'h23, 6'h00, 1'b1);          // lw
        fetch(); cyc("DECODE"); cyc("MEM_ADDR"); cyc("MEM_RD_W"); cyc("MEM_RD"); cyc("WB_LW");

        set_instr(6'h02, 6'h00, 1'b0);          // j
        fetch(); cyc("DECODE"); cyc("JUMP");
        set_instr(6'h00, 6'h08, 1'b0);          // jr
        fetch(); cyc("DECODE"); cyc("JR");

        set_instr(6'h00, 6'h21, 1'b0);          // unsupported funct
        fetch(); cyc("DECODE"); cyc("EXC"); exc_tail(2'd0);

        set_instr(6'h00, 6'h22, 1'b1);          // sub, overflow
        fetch(); cyc("DECODE"); cyc("EXEC_SUB"); cyc("EXC"); exc_tail(2'd1);

        sel = 1'b1; w = 3;
        rst_pulse();
        check("dut1_cause_cleared", 32'(bus1.exc_cause), 32'd0);

        set_instr(6'h23, 6'h00, 1'b0);          // lw with 3 wait states
        fetch(); cyc("DECODE"); cyc("MEM_ADDR");
        repeat (3) cyc("MEM_RD_W");
        cyc("MEM_RD"); cyc("WB_LW");

        fetch(); cyc("DECODE"); cyc("MEM_ADDR"); cyc("MEM_RD_W"); cyc("MEM_RD_W");
        reset = 1'b1;                           // abort mid read
        #1 check("rst_mid", 32'(got), 32'(model("RST")));
        check("rst_mid_cause", 32'(got_cause), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc("RST");
        fetch(); cyc("DECODE");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
